fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_buffer.sv | 120 ++++++++++++
 tb/tb_fetch_buffer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-buffer types: status FSM encoding, queue entry layout, default reset PC
// and the saturating counter helper used by the optional statistics.
package fetch_pkg;

  localparam int unsigned FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] FETCH_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  // Entries are packed PC-high, instruction-low.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      sat_inc16 = value;
    end else begin
      sat_inc16 = value + 16'd1;
    end
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular entry store for the fetch buffer; pointers wrap modulo DEPTH (a power of two).
// Reads are zero-latency from the head; the head reads as zero while empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;

  // Entry storage write port; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = (count_r != {CW{1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign count = count_r;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch buffer: PC generation, push/pop/flush control and status FSM around fetch_fifo.
// Optional FETCH_BUF_STATS_EN adds a saturating stall_cycles counter output.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              PC_STEP  = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [XLEN-1:0]            imem_data,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       dec_ready,
  output logic                       dec_valid,
  output logic [XLEN-1:0]            dec_instr,
  output logic [XLEN-1:0]            dec_pc,
  output logic [XLEN-1:0]            pc_current,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef FETCH_BUF_STATS_EN
  ,
  output logic [15:0]                stall_cycles
`endif
);

  localparam int              CW      = $clog2(DEPTH+1);
  localparam logic [XLEN-1:0] PC_INC  = XLEN'(PC_STEP);
  localparam logic [CW-1:0]   FULL_CT = CW'(DEPTH);

  fetch_state_e      state_r;
  logic [XLEN-1:0]   pc_r;
  logic [CW-1:0]     count_s;
  logic [2*XLEN-1:0] head_s;
  logic              full_s;
  logic              dec_valid_s;
  logic              push_s;
  logic              pop_s;
  logic              stall_s;

  assign full_s      = (count_s == FULL_CT);
  assign dec_valid_s = (count_s != {CW{1'b0}});

  // Redirect suppresses both ends; a full queue only accepts a push alongside a pop.
  always_comb begin
    push_s  = 1'b0;
    pop_s   = 1'b0;
    stall_s = 1'b0;
    if (redirect_valid) begin
      push_s  = 1'b0;
      pop_s   = 1'b0;
      stall_s = 1'b0;
    end else begin
      pop_s   = dec_valid_s & dec_ready;
      push_s  = fetch_en & (~full_s | pop_s);
      stall_s = fetch_en & full_s & ~pop_s;
    end
  end

  // PC register and status FSM; the state records what the previous cycle did.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r    <= RESET_PC;
      state_r <= ST_IDLE;
    end else if (redirect_valid) begin
      pc_r    <= redirect_pc;
      state_r <= ST_FLUSH;
    end else begin
      if (push_s) begin
        pc_r <= pc_r + PC_INC;
      end
      if (push_s) begin
        state_r <= ST_RUN;
      end else if (stall_s) begin
        state_r <= ST_STALL;
      end else begin
        state_r <= ST_IDLE;
      end
    end
  end

  fetch_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({pc_r, imem_data}),
    .rdata (head_s),
    .count (count_s)
  );

  assign imem_addr          = pc_r;
  assign pc_current         = pc_r;
  assign count              = count_s;
  assign dec_valid          = dec_valid_s;
  assign {dec_pc, dec_instr} = head_s;

`ifdef FETCH_BUF_STATS_EN
  logic [15:0] stall_cnt_r;

  // Stall statistics survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'd0;
    end else if (stall_s) begin
      stall_cnt_r <= sat_inc16(stall_cnt_r);
    end
  end

  assign stall_cycles = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: stimulus pushes expected entries, monitors pop and compare
// on every decode handshake. A second instance covers the PC wrap with RESET_PC=FFFFFFF8.
module tb_fetch_buffer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, fetch_en, redirect_valid, dec_ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, dec_instr, dec_pc, pc_current;
  logic        dec_valid;
  logic [2:0]  count;
`ifdef FETCH_BUF_STATS_EN
  logic [15:0] stall_cycles;
`endif

  logic        w_reset, w_fetch_en, w_dec_ready, w_dec_valid;
  logic [31:0] w_imem_addr, w_imem_data, w_dec_instr, w_dec_pc, w_pc_current;
  logic [2:0]  w_count;
`ifdef FETCH_BUF_STATS_EN
  logic [15:0] w_stall_cycles;
`endif

  int checks = 0;
  int failures = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t wexp_q[$];

  always #5 clk = ~clk;

  assign imem_data   = imem_addr + 32'h100;
  assign w_imem_data = w_imem_addr + 32'h100;

  fetch_buffer dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .dec_ready(dec_ready),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .pc_current(pc_current),
    .count(count)
`ifdef FETCH_BUF_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  fetch_buffer #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(w_reset), .fetch_en(w_fetch_en), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .redirect_valid(1'b0), .redirect_pc(32'h0), .dec_ready(w_dec_ready),
    .dec_valid(w_dec_valid), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc),
    .pc_current(w_pc_current), .count(w_count)
`ifdef FETCH_BUF_STATS_EN
    , .stall_cycles(w_stall_cycles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic expect_entry(input logic [31:0] pc, input logic [31:0] instr);
    fetch_entry_t e;
    e.pc    = pc;
    e.instr = instr;
    exp_q.push_back(e);
  endtask

  // Main-instance monitor: every accepted head entry must match the oldest expectation.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!reset && !redirect_valid && dec_valid && dec_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected actual_pc=%h expected=none", dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("mon_pc", dec_pc, e.pc);
        chk("mon_instr", dec_instr, e.instr);
      end
    end
  end

  // Wrap-instance monitor.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!w_reset && w_dec_valid && w_dec_ready) begin
      if (wexp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wmon_unexpected actual_pc=%h expected=none", w_dec_pc);
      end else begin
        e = wexp_q.pop_front();
        chk("wmon_pc", w_dec_pc, e.pc);
        chk("wmon_instr", w_dec_instr, e.instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fetch_entry_t we;
    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; dec_ready = 1'b0;
    w_reset = 1'b1; w_fetch_en = 1'b0; w_dec_ready = 1'b0;
    cycle(3);
    chk("rst_pc", pc_current, 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_decpc", dec_pc, 32'h0);
    chk("rst_state", 32'(dut.state_r), 32'(ST_IDLE));
`ifdef FETCH_BUF_STATS_EN
    chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif

    // Streaming: push and pop overlap, count stays at one.
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_entry(32'(4 * i), 32'h100 + 32'(4 * i));
      cycle(1);
      chk("stream_count", 32'(count), 32'd1);
      chk("stream_state", 32'(dut.state_r), 32'(ST_RUN));
    end
    fetch_en = 1'b0;
    cycle(1);
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_pc", pc_current, 32'd12);
    chk("drain_state", 32'(dut.state_r), 32'(ST_IDLE));

    // Fill to full with decode stalled.
    reset = 1'b1;
    cycle(1);
    reset = 1'b0; fetch_en = 1'b1; dec_ready = 1'b0;
    expect_entry(32'h0, 32'h100);
    expect_entry(32'h4, 32'h104);
    expect_entry(32'h8, 32'h108);
    expect_entry(32'hC, 32'h10C);
    cycle(6);
    chk("full_count", 32'(count), 32'd4);
    chk("full_pc", pc_current, 32'd16);
    chk("full_state", 32'(dut.state_r), 32'(ST_STALL));
    chk("full_head_pc", dec_pc, 32'h0);
    chk("full_head_instr", dec_instr, 32'h100);
`ifdef FETCH_BUF_STATS_EN
    chk("full_stall", 32'(stall_cycles), 32'd2);
`endif

    // Full queue with decode ready: push and pop every cycle.
    dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_entry(32'd16 + 32'(4 * i), 32'h110 + 32'(4 * i));
      cycle(1);
      chk("pp_count", 32'(count), 32'd4);
      chk("pp_pc", pc_current, 32'd20 + 32'(4 * i));
      chk("pp_state", 32'(dut.state_r), 32'(ST_RUN));
    end
`ifdef FETCH_BUF_STATS_EN
    chk("pp_stall", 32'(stall_cycles), 32'd2);
`endif

    // Drop to three entries, then redirect.
    fetch_en = 1'b0;
    cycle(1);
    chk("pre_redir_count", 32'(count), 32'd3);
    redirect_valid = 1'b1; redirect_pc = 32'h40; fetch_en = 1'b1;
    cycle(1);
    exp_q.delete();
    chk("redir_count", 32'(count), 32'd0);
    chk("redir_valid", 32'(dec_valid), 32'd0);
    chk("redir_pc", pc_current, 32'h40);
    chk("redir_decpc", dec_pc, 32'h0);
    chk("redir_state", 32'(dut.state_r), 32'(ST_FLUSH));
    redirect_valid = 1'b0;
    expect_entry(32'h40, 32'h140);
    cycle(1);
    chk("post_redir_count", 32'(count), 32'd1);
    chk("post_redir_state", 32'(dut.state_r), 32'(ST_RUN));
    fetch_en = 1'b0;
    cycle(1);
    chk("post_redir_drain", 32'(count), 32'd0);
    chk("post_redir_idle", 32'(dut.state_r), 32'(ST_IDLE));

    // Reset wins over a simultaneous redirect.
    fetch_en = 1'b1; dec_ready = 1'b0;
    cycle(2);
    chk("pre_rst_count", 32'(count), 32'd2);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
    cycle(1);
    chk("rr_pc", pc_current, 32'h0);
    chk("rr_count", 32'(count), 32'd0);
    chk("rr_valid", 32'(dec_valid), 32'd0);
    chk("rr_state", 32'(dut.state_r), 32'(ST_IDLE));
    reset = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
    cycle(1);
    chk("rr_hold_pc", pc_current, 32'h0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // PC wrap from RESET_PC=FFFFFFF8.
    w_reset = 1'b0; w_fetch_en = 1'b1; w_dec_ready = 1'b0;
    we.pc = 32'hFFFF_FFF8; we.instr = 32'h0000_00F8; wexp_q.push_back(we);
    we.pc = 32'hFFFF_FFFC; we.instr = 32'h0000_00FC; wexp_q.push_back(we);
    we.pc = 32'h0000_0000; we.instr = 32'h0000_0100; wexp_q.push_back(we);
    cycle(3);
    chk("wrap_count", 32'(w_count), 32'd3);
    chk("wrap_pc", w_pc_current, 32'h4);
    w_fetch_en = 1'b0; w_dec_ready = 1'b1;
    cycle(3);
    chk("wrap_drain", 32'(w_count), 32'd0);
    chk("wrap_queue", 32'(wexp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
